// File: rtl/ariane_pkg.sv
// Core-wide widths and the D$ request/response port types shared by the LSU blocks.
package ariane_pkg;

    localparam int unsigned XLEN               = 64;
    localparam int unsigned PLEN               = 56;
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = PLEN - DCACHE_INDEX_WIDTH;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [XLEN-1:0]               data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [XLEN/8-1:0]             data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic            data_gnt;
        logic            data_rvalid;
        logic [XLEN-1:0] data_rdata;
    } dcache_req_o_t;

endpackage

// File: rtl/store_resp_fifo.sv
// Circular write buffer: storage, wrapping pointers, occupancy count and per-entry valid bits.
module store_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [DEPTH-1:0][WIDTH-1:0]  entries_o,
    output logic [DEPTH-1:0]             valid_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
    logic                         push_ok, pop_ok;

    assign full_o    = (count_q == CW'(DEPTH));
    assign push_ok   = push_i & ~full_o;
    assign pop_ok    = pop_i & (count_q != '0);
    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;
    assign valid_o   = valid_q;
    assign count_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q]   = data_i;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/store_port_responder.sv
// D$ store port: buffers granted writes and drains them one at a time downstream,
// flagging loads whose page offset hits a pending write.
module store_port_responder
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  dcache_req_i_t     req_port_i,
    output dcache_req_o_t     req_port_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    input  logic              mem_ack_i,
    output logic [PLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [1:0]        mem_size_o,
    input  logic [11:0]       page_offset_i,
    output logic              page_offset_matches_o,
    output logic              empty_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        logic [XLEN/8-1:0] be;
        logic [1:0]        size;
    } entry_t;

    localparam int unsigned EW = $bits(entry_t);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_e;

    state_e                   state_q, state_d;
    logic                     rvalid_q, rvalid_d;
    logic                     gnt, pop, full;
    logic [CW-1:0]            count;
    entry_t                   push_entry, head;
    logic [DEPTH-1:0][EW-1:0] entries;
    logic [DEPTH-1:0]         valid;
    logic                     unused_bits;

    assign gnt = req_port_i.data_req & req_port_i.data_we & ~full;

    always_comb begin
        push_entry.addr = {req_port_i.address_tag, req_port_i.address_index};
        push_entry.data = req_port_i.data_wdata;
        push_entry.be   = req_port_i.data_be;
        push_entry.size = req_port_i.data_size;
    end

    store_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) i_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (gnt),
        .data_i    (push_entry),
        .pop_i     (pop),
        .head_o    (head),
        .entries_o (entries),
        .valid_o   (valid),
        .count_o   (count),
        .full_o    (full)
    );

    // A push while IDLE starts the drain next cycle, so mem_req_o rises one cycle after grant.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        mem_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0 || gnt) state_d = REQ;
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    if (mem_ack_i) begin
                        pop     = 1'b1;
                        state_d = (count == CW'(1)) ? IDLE : REQ;
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (mem_ack_i) begin
                    pop     = 1'b1;
                    state_d = (count == CW'(1)) ? IDLE : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rvalid_d = gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        page_offset_matches_o = gnt &&
            (req_port_i.address_index[11:3] == page_offset_i[11:3]);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i][EW-PLEN+11 -: 9] == page_offset_i[11:3]))
                page_offset_matches_o = 1'b1;
        end
    end

    always_comb begin
        req_port_o             = '0;
        req_port_o.data_gnt    = gnt;
        req_port_o.data_rvalid = rvalid_q;
    end

    assign mem_addr_o  = head.addr;
    assign mem_wdata_o = head.data;
    assign mem_be_o    = head.be;
    assign mem_size_o  = head.size;
    assign empty_o     = (count == '0) && (state_q == IDLE);

    assign unused_bits = ^{entries, req_port_i.kill_req, req_port_i.tag_valid, page_offset_i[2:0]};

endmodule

// File: tb/tb_store_port_responder.sv
// Randomized + directed bench; a queue of accepted-but-unacked writes is the reference model.
module tb_store_port_responder;
    import ariane_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    dcache_req_i_t     req_i;
    dcache_req_o_t     req_o;
    logic              mem_req, mem_gnt, mem_ack;
    logic [PLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_be;
    logic [1:0]        mem_size;
    logic [11:0]       page_off;
    logic              match, empty;

    always #5 clk = ~clk;

    store_port_responder #(.DEPTH(DEPTH)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .req_port_i            (req_i),
        .req_port_o            (req_o),
        .mem_req_o             (mem_req),
        .mem_gnt_i             (mem_gnt),
        .mem_ack_i             (mem_ack),
        .mem_addr_o            (mem_addr),
        .mem_wdata_o           (mem_wdata),
        .mem_be_o              (mem_be),
        .mem_size_o            (mem_size),
        .page_offset_i         (page_off),
        .page_offset_matches_o (match),
        .empty_o               (empty)
    );

    typedef struct {
        logic [PLEN-1:0] addr;
        logic [63:0]     data;
        logic [7:0]      be;
        logic [1:0]      size;
    } wr_t;

    wr_t         pend[$];
    logic [63:0] seen[$];
    int          n_cmp = 0, n_fail = 0;
    logic        prev_gnt = 1'b0, m_out = 1'b0, r_out = 1'b0;
    int          mode = 0;
    logic        fgnt = 1'b0, fack = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: everything sampled on the falling edge.
    initial begin : mon
        logic eg, em, hs, done;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                chk("rst_empty", empty, 1);
                chk("rst_mem_req", mem_req, 0);
                chk("rst_rvalid", req_o.data_rvalid, 0);
                chk("rst_gnt", req_o.data_gnt, req_i.data_req & req_i.data_we);
                chk("rst_match", match, req_i.data_req & req_i.data_we &
                    (req_i.address_index[11:3] == page_off[11:3]));
                pend.delete();
                m_out    = 1'b0;
                prev_gnt = 1'b0;
            end else begin
                eg = req_i.data_req && req_i.data_we && (pend.size() < DEPTH);
                chk("gnt", req_o.data_gnt, eg);
                chk("rvalid", req_o.data_rvalid, prev_gnt);
                chk("rdata", req_o.data_rdata, 0);
                chk("empty", empty, pend.size() == 0);
                em = eg && (req_i.address_index[11:3] == page_off[11:3]);
                foreach (pend[i]) if (pend[i].addr[11:3] == page_off[11:3]) em = 1'b1;
                chk("match", match, em);
                if (mem_req) begin
                    chk("one_outstanding", m_out, 0);
                    if (pend.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL mem_req_no_pending: got mem_req=1 expected 0 (t=%0t)", $time);
                    end else begin
                        chk("mem_addr", mem_addr, pend[0].addr);
                        chk("mem_wdata", mem_wdata, pend[0].data);
                        chk("mem_be", mem_be, pend[0].be);
                        chk("mem_size", mem_size, pend[0].size);
                    end
                end
                hs    = mem_req && mem_gnt;
                done  = mem_ack && (m_out || hs);
                m_out = (m_out || hs) && !mem_ack;
                if (hs) seen.push_back(mem_wdata);
                if (done && pend.size() > 0) void'(pend.pop_front());
                if (eg) begin
                    w.addr = {req_i.address_tag, req_i.address_index};
                    w.data = req_i.data_wdata;
                    w.be   = req_i.data_be;
                    w.size = req_i.data_size;
                    pend.push_back(w);
                end
                prev_gnt = eg;
            end
        end
    end

    // Downstream memory: 0 = stalled, 1 = random gnt/ack, 2 = forced from fgnt/fack.
    initial begin : resp
        mem_gnt = 1'b0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (rst_i) begin
                r_out = 1'b0; mem_gnt = 1'b0; mem_ack = 1'b0;
            end else begin
                case (mode)
                    1: begin
                        if (!r_out) begin
                            mem_gnt = mem_req && ($urandom_range(0, 2) != 0);
                            mem_ack = mem_gnt && ($urandom_range(0, 3) == 0);
                        end else begin
                            mem_gnt = 1'($urandom_range(0, 1));
                            mem_ack = ($urandom_range(0, 2) == 0);
                        end
                    end
                    2: begin mem_gnt = fgnt; mem_ack = fack; end
                    default: begin mem_gnt = 1'b0; mem_ack = 1'b0; end
                endcase
                r_out = (r_out || (mem_req && mem_gnt)) && !mem_ack;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input logic [PLEN-1:0] a, input logic [63:0] d,
                           input logic [7:0] be, input logic [1:0] sz);
        req_i.data_req      = 1'b1;
        req_i.data_we       = 1'b1;
        req_i.address_index = a[11:0];
        req_i.address_tag   = a[PLEN-1:12];
        req_i.data_wdata    = d;
        req_i.data_be       = be;
        req_i.data_size     = sz;
        req_i.kill_req      = 1'($urandom_range(0, 1));
        req_i.tag_valid     = 1'($urandom_range(0, 1));
    endtask

    task automatic wr(input logic [PLEN-1:0] a, input logic [63:0] d,
                      input logic [7:0] be, input logic [1:0] sz);
        bit got = 0;
        set_req(a, d, be, sz);
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = req_o.data_gnt;
            cyc();
        end
        req_i.data_req = 1'b0;
        chk("wr_grant_timeout", got, 1);
    endtask

    task automatic wait_mem_req();
        bit got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = mem_req;
            cyc();
        end
        chk("mem_req_timeout", got, 1);
    endtask

    task automatic wait_empty();
        bit got = 0;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge clk);
            got = empty;
            cyc();
        end
        chk("drain_timeout", got, 1);
    endtask

    function automatic logic [PLEN-1:0] rnd_addr();
        logic [PLEN-1:0] a;
        a        = {$urandom, $urandom};
        a[11:0]  = 12'(12'h400 + $urandom_range(0, 7) * 8 + $urandom_range(0, 7));
        return a;
    endfunction

    initial begin : drv
        int g;
        bit got;
        rst_i    = 1'b1;
        req_i    = '0;
        page_off = '0;
        repeat (3) cyc();
        rst_i = 1'b0;
        cyc();

        // Single write: grant cycle 0, rvalid and mem_req cycle 1, ack two cycles later.
        mode = 2; fgnt = 1'b1; fack = 1'b0;
        set_req(56'h0000_8000_1008, 64'h1122_3344_5566_7788, 8'hFF, 2'b11);
        @(negedge clk); chk("single_gnt_c0", req_o.data_gnt, 1);
        cyc(); req_i.data_req = 1'b0;
        @(negedge clk); chk("single_rvalid_c1", req_o.data_rvalid, 1);
        chk("single_memreq_c1", mem_req, 1);
        chk("single_addr_c1", mem_addr, 56'h0000_8000_1008);
        cyc(); fgnt = 1'b0;
        @(negedge clk); chk("single_waitack_c2", mem_req, 0);
        cyc(); fack = 1'b1;
        cyc(); fack = 1'b0;
        @(negedge clk); chk("single_empty_after_ack", empty, 1);
        cyc();

        // Fill with downstream stalled: only DEPTH grants out of five requests.
        mode = 0; g = 0;
        set_req(rnd_addr(), 64'd0, 8'h0F, 2'b10);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_o.data_gnt) g++;
            cyc();
            req_i.data_wdata = 64'(g);
        end
        chk("fill_grants", g, DEPTH);
        @(negedge clk); chk("fill_full_no_gnt", req_o.data_gnt, 0);
        cyc();
        mode = 1; got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk); got = req_o.data_gnt; cyc();
        end
        req_i.data_req = 1'b0;
        chk("fill_fifth_after_ack", got, 1);
        wait_empty();

        // Wrap: ten sequential writes, random downstream timing.
        seen.delete();
        for (int i = 0; i < 10; i++)
            wr(rnd_addr(), 64'(i), 8'($urandom), 2'($urandom_range(0, 3)));
        wait_empty();
        chk("wrap_count", seen.size(), 10);
        foreach (seen[i]) chk("wrap_order", seen[i], 64'(i));

        // Hazard against a pending entry with addr[11:3] = 0x1A2.
        mode = 0;
        wr({44'h0_0000_0123, 12'hD10}, 64'hDEAD, 8'hFF, 2'b11);
        page_off = 12'hD10;
        @(negedge clk); chk("hazard_hit", match, 1); cyc();
        page_off = 12'hD17;
        @(negedge clk); chk("hazard_hit_same_dword", match, 1); cyc();
        page_off = 12'hD18;
        @(negedge clk); chk("hazard_miss", match, 0); cyc();
        mode = 1;
        wait_empty();

        // Same-cycle gnt+ack pops without WAIT_ACK; push alongside a pop keeps the count.
        mode = 2; fgnt = 1'b0; fack = 1'b0;
        wr(rnd_addr(), 64'hA, 8'h01, 2'b00);
        wr(rnd_addr(), 64'hB, 8'h03, 2'b01);
        wait_mem_req();
        fgnt = 1'b1; fack = 1'b1;
        cyc(); fgnt = 1'b0; fack = 1'b0;
        @(negedge clk); chk("gnt_ack_skip_wait", mem_req, 1);
        chk("gnt_ack_next_head", mem_wdata, 64'hB);
        cyc(); fgnt = 1'b1;
        cyc(); fgnt = 1'b0;
        @(negedge clk); chk("in_wait_ack", mem_req, 0);
        cyc(); fack = 1'b1;
        set_req(rnd_addr(), 64'hC, 8'hF0, 2'b10);
        @(negedge clk); chk("push_with_pop_gnt", req_o.data_gnt, 1);
        cyc(); fack = 1'b0; req_i.data_req = 1'b0;
        @(negedge clk); chk("push_pop_count_kept", empty, 0);
        cyc();
        mode = 1;
        wait_empty();

        // Reset while WAIT_ACK with three entries, then a stray ack.
        mode = 2; fgnt = 1'b0; fack = 1'b0;
        for (int i = 0; i < 3; i++) wr(rnd_addr(), 64'(16 + i), 8'hFF, 2'b11);
        wait_mem_req();
        fgnt = 1'b1;
        cyc(); fgnt = 1'b0;
        @(negedge clk); chk("pre_rst_wait_ack", mem_req, 0);
        chk("pre_rst_not_empty", empty, 0);
        cyc(); rst_i = 1'b1;
        @(negedge clk); chk("rst_mid_empty", empty, 1); chk("rst_mid_mem_req", mem_req, 0);
        cyc(); rst_i = 1'b0; fack = 1'b1;
        @(negedge clk); chk("late_ack_empty", empty, 1); chk("late_ack_mem_req", mem_req, 0);
        cyc(); fack = 1'b0;
        @(negedge clk); chk("late_ack_no_pop", empty, 1); chk("late_ack_idle", mem_req, 0);
        cyc();

        // Randomized mix of writes, non-write requests and idle cycles.
        mode = 1;
        for (int it = 0; it < 150; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (pend.size() > 0 && $urandom_range(0, 1) == 1)
                page_off = pend[$urandom_range(0, pend.size() - 1)].addr[11:0];
            else
                page_off = 12'($urandom);
            if (op < 6) begin
                wr(rnd_addr(), {$urandom, $urandom}, 8'($urandom), 2'($urandom_range(0, 3)));
            end else if (op == 6) begin
                set_req(rnd_addr(), 64'd0, 8'hFF, 2'b11);
                req_i.data_we = 1'b0;
                @(negedge clk); cyc();
                req_i.data_req = 1'b0;
            end else begin
                cyc();
            end
        end
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/store_port_responder.md
STORE_PORT_RESPONDER -- requirements
Module: store_port_responder

Interface
REQ-001 Param DEPTH, default 4, write-buffer entries; power of two, at least 2.
REQ-002 Port clk_i  in  1  sole clock, rising edge.
REQ-003 Port rst_i  in  1  asynchronous, active-high reset.
REQ-004 Port req_port_i  in  dcache_req_i_t  D$ write request: data_req, data_we, address_index, address_tag, data_wdata, data_be, data_size, kill_req, tag_valid.
REQ-005 Port req_port_o  out  dcache_req_o_t  data_gnt, data_rvalid, data_rdata.
REQ-006 Port mem_req_o  out  1  downstream write request.
REQ-007 Port mem_gnt_i  in  1  downstream grant.
REQ-008 Port mem_ack_i  in  1  downstream write-complete pulse.
REQ-009 Port mem_addr_o  out  PLEN  physical write address.
REQ-010 Port mem_wdata_o  out  XLEN  write data.
REQ-011 Port mem_be_o  out  XLEN/8  byte enables.
REQ-012 Port mem_size_o  out  2  access size.
REQ-013 Port page_offset_i  in  12  load page offset to check against pending writes.
REQ-014 Port page_offset_matches_o  out  1  a pending write matches page_offset_i[11:3].
REQ-015 Port empty_o  out  1  buffer empty and drain FSM idle.

Function
REQ-016 Accept: data_gnt = data_req & data_we & !full, same cycle (combinational); requests with data_we=0 are never granted.
REQ-017 On grant, push {address_tag, address_index}, wdata, be, size at the write pointer; the write pointer wraps modulo DEPTH.
REQ-018 data_rvalid is asserted exactly one cycle after each grant; data_rdata is '0.
REQ-019 kill_req and tag_valid are ignored; the tag is sampled in the grant cycle.
REQ-020 Count width is $clog2(DEPTH)+1; full = (count==DEPTH); a simultaneous push and pop leaves the count unchanged.
REQ-021 Drain FSM states: IDLE, REQ, WAIT_ACK.
REQ-022 IDLE -> REQ when count!=0; the head entry drives the mem_* outputs.
REQ-023 In REQ, mem_req_o=1 and the mem_* outputs are held stable until mem_gnt_i; on grant, go to WAIT_ACK.
REQ-024 In WAIT_ACK, on mem_ack_i: pop the head, advance the read pointer with wrap, and go to REQ if count-1!=0, else go to IDLE.
REQ-025 A mem_ack_i in the same cycle as mem_gnt_i is legal; the FSM then pops directly and skips WAIT_ACK.
REQ-026 Only one downstream write is outstanding at a time; the head entry stays valid until acked.
REQ-027 A push into a full buffer is impossible: gnt=0; full is computed from count_q, so a pop in the same cycle does not free a slot that cycle.
REQ-028 page_offset_matches_o = OR over valid entries of (addr[11:3]==page_offset_i[11:3]), plus the incoming granted request; combinational.
REQ-029 empty_o = (count_q==0) & (state==IDLE).
REQ-030 Accepted writes are never dropped; there is no flush input.

Reset
REQ-031 On rst_i asserted: pointers=0, count=0, all entry valid bits=0, FSM=IDLE, data_rvalid=0, mem_req_o=0.
REQ-032 Outputs during reset: data_gnt follows REQ-016 (buffer empty); page_offset_matches_o=0 unless a request is incoming; empty_o=1.
REQ-033 Reset mid-drain abandons the outstanding write; a mem_ack_i arriving after reset is ignored while in IDLE.

Structure
REQ-034 dcache_req_i_t, dcache_req_o_t, DCACHE_INDEX_WIDTH and DCACHE_TAG_WIDTH come from ariane_pkg.
REQ-035 The entry struct and the FSM state enum are local to the module.
REQ-036 One sub-module is natural: store_resp_fifo (storage, pointers, count); the FSM and the match logic live in the top.

Verification
REQ-037 Single write, addr 0x8000_1008, be 0xFF, data_req held, mem_gnt immediate, ack +2 -> gnt cycle 0; rvalid cycle 1; mem_req cycle 1; empty_o=1 after ack.
REQ-038 Fill: DEPTH=4, mem_gnt_i=0, 5 back-to-back requests -> 4 grants; 5th gnt=0 until the first ack frees a slot.
REQ-039 Wrap: 10 writes with sequential data 0..9, random gnt/ack delays -> mem_wdata_o order 0..9, count returns to 0.
REQ-040 Hazard: pending entry addr[11:3]=0x1A2; page_offset_i=0xD10 -> match=1; page_offset_i=0xD18 -> match=0.
REQ-041 Simultaneous events: push in the same cycle as the head ack -> count unchanged; mem_gnt_i and mem_ack_i in the same cycle -> pop without WAIT_ACK.
REQ-042 Reset asserted in WAIT_ACK with 3 entries -> next cycle empty_o=1, mem_req_o=0; a late mem_ack_i causes no pop.
